// File: rtl/multi_pkg.sv
// Shared definitions for the multiplier arbiter and related shared-resource blocks.
//   state_e      : arbiter FSM encoding (IDLE=0, BUSY=1, DONE=2)
//   *_DEF        : default parameter values
//   idx_width()  : index width for an N-entry requester vector
package multi_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 40;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req   : request vector
//   ptr   : highest-priority slot; search runs upward from here, wrapping
//   grant : one-hot grant (zero when no request)
//   idx   : binary index of the granted slot
//   found : at least one request was present
module rr_pick
    import multi_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            pos = (int'(ptr) + i) % int'(NREQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDXW'(pos);
            end
        end
    end

endmodule

// File: rtl/multi_arbiter.sv
// Round-robin arbiter sharing one fixed-latency signed multiplier among NREQ requesters.
//   clock, reset           : rising-edge clock, async active-low reset
//   req / req_mlier / mcand: per-slot request level and packed signed operands
//   ack, done              : one-hot single-cycle pulses (operands captured / result valid)
//   rsp_prodt, rsp_err     : shared result; rsp_err marks a watchdog abort
//   busy                   : FSM not idle
//   mul_*                  : handshake and operands toward the external multiplier
module multi_arbiter
    import multi_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNTW    = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [WIDTH*NREQ-1:0]   req_mlier,
    input  logic [WIDTH*NREQ-1:0]   req_mcand,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      rsp_prodt,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_mlier,
    output logic [WIDTH-1:0]        mul_mcand,
    input  logic [2*WIDTH-1:0]      mul_prodt,
    input  logic                    mul_valid
);

    localparam int unsigned IDXW = idx_width(NREQ);

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [IDXW-1:0]   rr_q;
    logic [CNTW-1:0]   wd_q;
    logic              valid_q;

    logic [NREQ-1:0]   pick_grant;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_found;
    logic              valid_edge;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A valid level already high when BUSY is entered is not a new result.
    assign valid_edge = mul_valid & ~valid_q;
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            rr_q      <= '0;
            wd_q      <= '0;
            valid_q   <= 1'b0;
            ack       <= '0;
            done      <= '0;
            rsp_prodt <= '0;
            rsp_err   <= 1'b0;
            mul_start <= 1'b0;
            mul_mlier <= '0;
            mul_mcand <= '0;
        end else begin
            ack     <= '0;
            done    <= '0;
            valid_q <= mul_valid;
            case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        ack       <= pick_grant;
                        idx_q     <= pick_idx;
                        mul_mlier <= req_mlier[32'(pick_idx) * WIDTH +: WIDTH];
                        mul_mcand <= req_mcand[32'(pick_idx) * WIDTH +: WIDTH];
                        wd_q      <= '0;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    wd_q <= wd_q + 1'b1;
                    if (valid_edge) begin
                        rsp_prodt <= mul_prodt;
                        rsp_err   <= 1'b0;
                        mul_start <= 1'b0;
                        state_q   <= StDone;
                    end else if (wd_q == CNTW'(TIMEOUT)) begin
                        rsp_prodt <= '0;
                        rsp_err   <= 1'b1;
                        mul_start <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        mul_start <= 1'b1;
                    end
                end
                StDone: begin
                    done[idx_q] <= 1'b1;
                    rr_q        <= (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_arbiter.sv
module tb_multi_arbiter;
    import multi_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned TO   = 40;
    localparam int unsigned LAT  = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [W*NREQ-1:0] req_mlier = '0;
    logic [W*NREQ-1:0] req_mcand = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [2*W-1:0]    rsp_prodt;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_mlier;
    logic [W-1:0]      mul_mcand;
    logic [2*W-1:0]    mul_prodt = '0;
    logic              mul_valid = 1'b0;

    multi_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (W),
        .TIMEOUT (TO),
        .CNTW    (6)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_mlier (req_mlier),
        .req_mcand (req_mcand),
        .ack       (ack),
        .done      (done),
        .rsp_prodt (rsp_prodt),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_mlier (mul_mlier),
        .mul_mcand (mul_mcand),
        .mul_prodt (mul_prodt),
        .mul_valid (mul_valid)
    );

    always #5 clock = ~clock;

    // Fixed-latency multiplier model; 'stuck' turns it into a unit that never answers.
    bit                 stuck = 1'b0;
    int                 mcnt  = 0;
    logic signed [63:0] model_p;
    assign model_p = $signed(mul_mlier) * $signed(mul_mcand);

    always @(posedge clock) begin
        if (!mul_start || stuck) begin
            mcnt      <= 0;
            mul_valid <= 1'b0;
        end else if (mcnt == int'(LAT)) begin
            mul_valid <= 1'b1;
            mul_prodt <= model_p;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int low_run = 0;
    int last_low_run = 0;
    int t_ack = 0;
    int t_done = 0;
    int t_valid = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (!mul_start) begin
            low_run++;
        end else begin
            if (low_run > 0) last_low_run = low_run;
            low_run = 0;
        end
    endtask

    task automatic set_ops(input int slot, input logic [31:0] a, input logic [31:0] b);
        req_mlier[slot*W +: W] = a;
        req_mcand[slot*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One full operation: wait for ack, check start, wait for done, check result.
    task automatic do_op(input string tag, input logic [3:0] exp_grant,
                         input logic [63:0] exp_prod, input logic exp_err, input bit hold);
        logic [3:0] g;
        logic [3:0] d;
        g = '0;
        for (int k = 0; k < 100 && g == 0; k++) begin
            tick();
            g = ack;
        end
        t_ack = cyc;
        check({tag, "_ack"}, 64'(g), 64'(exp_grant));
        if (!hold) req = req & ~g;
        tick();
        check({tag, "_start"}, 64'(mul_start), 64'd1);
        d = '0;
        t_valid = -1;
        for (int k = 0; k < 200 && d == 0; k++) begin
            tick();
            if (mul_valid === 1'b1 && t_valid < 0) t_valid = cyc;
            d = done;
        end
        t_done = cyc;
        check({tag, "_done"}, 64'(d), 64'(exp_grant));
        check({tag, "_prod"}, rsp_prodt, exp_prod);
        check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        if (!stuck) check({tag, "_lat"}, 64'(t_done - t_valid), 64'd2);
    endtask

    initial begin
        logic signed [63:0] exp_p;
        int                 slot;

        // Reset state
        tick();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(mul_start), 64'd0);
        check("rst_prod", rsp_prodt, 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_mlier", 64'(mul_mlier), 64'd0);
        reset = 1'b1;
        tick();

        // Single request: 7 x -3
        set_ops(0, 32'd7, 32'hFFFF_FFFD);
        req = 4'b0001;
        do_op("single", 4'b0001, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
        tick();
        check("single_busy_after", 64'(busy), 64'd0);
        check("single_done_pulse", 64'(done), 64'd0);

        // Simultaneous requests from pointer 0
        do_reset();
        set_ops(1, 32'd5, 32'd6);
        set_ops(2, 32'hFFFF_FFFC, 32'd9);
        req = 4'b0110;
        do_op("simul1", 4'b0010, 64'd30, 1'b0, 1'b0);
        do_op("simul2", 4'b0100, 64'hFFFF_FFFF_FFFF_FFDC, 1'b0, 1'b0);
        check("simul_start_gap", 64'(last_low_run >= 2), 64'd1);

        // Fairness with all requests held
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) set_ops(i, $urandom, $urandom);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            slot  = k % 4;
            exp_p = $signed(req_mlier[slot*W +: W]) * $signed(req_mcand[slot*W +: W]);
            do_op($sformatf("fair%0d", k), 4'(1 << slot), exp_p, 1'b0, 1'b1);
            set_ops(slot, $urandom, $urandom);
        end
        req = 4'b0000;

        // Signed extremes
        set_ops(1, 32'h8000_0000, 32'h8000_0000);
        req = 4'b0010;
        do_op("ext_minmin", 4'b0010, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        set_ops(1, 32'h8000_0000, 32'h7FFF_FFFF);
        req = 4'b0010;
        do_op("ext_minmax", 4'b0010, 64'hC000_0000_8000_0000, 1'b0, 1'b0);

        // Watchdog abort, then recovery
        stuck = 1'b1;
        set_ops(0, 32'd3, 32'd4);
        req = 4'b0001;
        do_op("timeout", 4'b0001, 64'd0, 1'b1, 1'b0);
        check("timeout_lat", 64'(t_done - t_ack), 64'(TO + 2));
        stuck = 1'b0;
        set_ops(2, 32'hFFFF_FFFE, 32'd8);
        req = 4'b0100;
        do_op("recover", 4'b0100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);

        // Reset in the middle of BUSY
        stuck = 1'b1;
        set_ops(0, 32'd1, 32'd1);
        req = 4'b0001;
        begin
            logic [3:0] g;
            g = '0;
            for (int k = 0; k < 100 && g == 0; k++) begin
                tick();
                g = ack;
            end
            check("midrst_ack", 64'(g), 64'd1);
        end
        req = 4'b0000;
        repeat (10) tick();
        check("midrst_pre_start", 64'(mul_start), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_start", 64'(mul_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        stuck = 1'b0;
        set_ops(3, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
        req = 4'b1000;
        do_op("after_rst", 4'b1000, 64'd42, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
